// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one instruction at a time, holds it until
// the execute stage retires it, then selects the next PC (sequential/branch/jump).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRValid,
  input  logic [31:0] imemRData,
  output logic [31:0] instrCode,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  input  logic        retire,
  input  logic        branch,
  input  logic        btaken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] immExt,
  input  logic [31:0] rs1Data,
  output logic        fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic        req_reg;
  logic        valid_reg;
  logic        fault_reg;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_reg + 32'd4;

  // jalr has top priority and always clears bit 0 of its target
  always_comb begin
    next_pc = pc_plus4;
    if (jalr)
      next_pc = (rs1Data + immExt) & ~32'h1;
    else if (jal || (branch && btaken))
      next_pc = pc_reg + immExt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_REQ;
      pc_reg    <= RESET_PC;
      instr_reg <= NOP;
      req_reg   <= 1'b1;
      valid_reg <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (imemGnt) begin
            state_reg <= S_WAIT;
            req_reg   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imemRValid) begin
            instr_reg <= imemRData;
            state_reg <= S_HOLD;
            valid_reg <= 1'b1;
          end
        end
        S_HOLD: begin
          if (retire) begin
            valid_reg <= 1'b0;
            // a target with bit 1 set is not word aligned: park until reset
            if (next_pc[1]) begin
              state_reg <= S_FAULT;
              fault_reg <= 1'b1;
            end else begin
              pc_reg    <= next_pc;
              state_reg <= S_REQ;
              req_reg   <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= S_FAULT;
        end
      endcase
    end
  end

  assign imemReq    = req_reg;
  assign imemAddr   = pc_reg;
  assign pc         = pc_reg;
  assign pcPlus4    = pc_plus4;
  assign instrCode  = instr_reg;
  assign instrValid = valid_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: fetched words are queued when memory
// returns them and compared when the unit presents instrValid.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemRValid = 1'b0;
  logic [31:0] imemRData = 32'h0;
  logic [31:0] instrCode;
  logic        instrValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        retire = 1'b0;
  logic        branch = 1'b0;
  logic        btaken = 1'b0;
  logic        jal = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] immExt = 32'h0;
  logic [31:0] rs1Data = 32'h0;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model_pc;
  logic [31:0] last_instr;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRValid(imemRValid), .imemRData(imemRData),
    .instrCode(instrCode), .instrValid(instrValid),
    .pc(pc), .pcPlus4(pcPlus4),
    .retire(retire), .branch(branch), .btaken(btaken), .jal(jal), .jalr(jalr),
    .immExt(immExt), .rs1Data(rs1Data), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle: outputs must change before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_req", {31'b0, imemReq}, 32'd1);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instrCode, 32'h0000_0013);
    check("rst_valid", {31'b0, instrValid}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    step();
    reset = 1'b0;
    model_pc = 32'h0;
    last_instr = 32'h0000_0013;
    sb.delete();
    $display("reset pc=%h instr=%h", pc, instrCode);
  endtask

  task automatic fetch(input int stall, input logic [31:0] data);
    int n;
    exp_t e;
    check("req_addr", imemAddr, model_pc);
    check("req_on", {31'b0, imemReq}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      imemGnt = 1'b0;
      imemRValid = 1'b1;          // must be ignored while requesting
      imemRData = 32'hDEAD_BEEF;
      step();
      check("stall_req", {31'b0, imemReq}, 32'd1);
      check("stall_addr", imemAddr, model_pc);
      check("stall_valid", {31'b0, instrValid}, 32'd0);
    end
    imemRValid = 1'b0;
    imemGnt = 1'b1;
    step();
    imemGnt = 1'b0;
    check("wait_req", {31'b0, imemReq}, 32'd0);
    check("wait_valid", {31'b0, instrValid}, 32'd0);
    imemRValid = 1'b1;
    imemRData = data;
    sb.push_back('{pc: model_pc, instr: data});
    step();
    imemRValid = 1'b0;
    n = 0;
    while (!instrValid && n < 8) begin
      step();
      n++;
    end
    check("valid_seen", {31'b0, instrValid}, 32'd1);
    check("latency", n, 32'd0);
    if (instrValid && sb.size() > 0) begin
      e = sb.pop_front();
      check("instr", instrCode, e.instr);
      check("pc", pc, e.pc);
      check("pc4", pcPlus4, e.pc + 32'd4);
      last_instr = e.instr;
    end
    $display("fetch pc=%h instr=%h stall=%0d", pc, instrCode, stall);
  endtask

  task automatic retire_op(input logic br, input logic bt, input logic j, input logic jr,
                           input logic [31:0] imm, input logic [31:0] rs1,
                           input logic [31:0] exp_next, input logic exp_fault);
    // a cycle of noisy control inputs without retire must change nothing
    branch = 1'b1; btaken = 1'b1; jal = 1'b1; jalr = 1'b1;
    immExt = $urandom; rs1Data = $urandom; retire = 1'b0;
    step();
    check("hold_pc", pc, model_pc);
    check("hold_valid", {31'b0, instrValid}, 32'd1);
    check("hold_instr", instrCode, last_instr);
    branch = br; btaken = bt; jal = j; jalr = jr; immExt = imm; rs1Data = rs1;
    retire = 1'b1;
    step();
    retire = 1'b0; branch = 1'b0; btaken = 1'b0; jal = 1'b0; jalr = 1'b0;
    if (exp_fault) begin
      for (int i = 0; i < 3; i++) begin
        imemGnt = 1'b1; imemRValid = 1'b1; imemRData = 32'hBAD0_BAD0;
        check("flt_fault", {31'b0, fault}, 32'd1);
        check("flt_req", {31'b0, imemReq}, 32'd0);
        check("flt_valid", {31'b0, instrValid}, 32'd0);
        check("flt_pc", pc, model_pc);
        step();
      end
      imemGnt = 1'b0; imemRValid = 1'b0;
      check("flt_instr", instrCode, last_instr);
      check("flt_stay", {31'b0, fault}, 32'd1);
    end else begin
      check("next_pc", pc, exp_next);
      check("next_req", {31'b0, imemReq}, 32'd1);
      check("next_valid", {31'b0, instrValid}, 32'd0);
      check("next_fault", {31'b0, fault}, 32'd0);
      check("keep_instr", instrCode, last_instr);
      model_pc = exp_next;
    end
    $display("retire br=%0b bt=%0b jal=%0b jalr=%0b -> pc=%h fault=%0b", br, bt, j, jr, pc, fault);
  endtask

  initial begin
    model_pc = 32'h0;
    last_instr = 32'h0000_0013;
    @(negedge clk);
    do_reset();

    // sequential fetch and retire
    fetch(0, 32'h0000_0093);
    retire_op(0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0);
    check("seq_addr", imemAddr, 32'h4);
    // stalled grant
    fetch(3, 32'h1111_0001);
    retire_op(0, 0, 0, 0, 32'h0, 32'h0, 32'h8, 0);
    fetch(0, 32'h1111_0002);
    retire_op(0, 0, 0, 0, 32'h0, 32'h0, 32'hC, 0);
    fetch(1, 32'h1111_0003);
    retire_op(0, 0, 0, 0, 32'h0, 32'h0, 32'h10, 0);
    // branch taken backwards
    fetch(0, 32'h2222_0001);
    retire_op(1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h8, 0);
    fetch(0, 32'h2222_0002);
    retire_op(0, 0, 0, 0, 32'h0, 32'h0, 32'hC, 0);
    fetch(0, 32'h2222_0003);
    retire_op(0, 0, 0, 0, 32'h0, 32'h0, 32'h10, 0);
    // branch not taken
    fetch(2, 32'h2222_0004);
    retire_op(1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h14, 0);
    // jalr beats jal, bit 0 cleared
    fetch(0, 32'h3333_0001);
    retire_op(1, 1, 1, 1, 32'h4, 32'h101, 32'h104, 0);
    // jal forward
    fetch(0, 32'h3333_0002);
    retire_op(0, 0, 1, 0, 32'h10, 32'h0, 32'h114, 0);
    // jump to top of address space, then wrap
    fetch(0, 32'h3333_0003);
    retire_op(0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    fetch(0, 32'h4444_0001);
    check("wrap_pc4", pcPlus4, 32'h0);
    retire_op(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    // misaligned jal target
    fetch(0, 32'h5555_0001);
    retire_op(0, 0, 1, 0, 32'h6, 32'h0, 32'h0, 1);

    // reset during WAIT, late rvalid after release
    do_reset();
    check("rw_req", {31'b0, imemReq}, 32'd1);
    imemGnt = 1'b1;
    step();
    imemGnt = 1'b0;
    check("rw_wait", {31'b0, imemReq}, 32'd0);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    imemRValid = 1'b1;
    imemRData = 32'h7777_7777;
    step();
    imemRValid = 1'b0;
    check("rw_instr", instrCode, 32'h0000_0013);
    check("rw_pc", pc, 32'h0);
    check("rw_valid", {31'b0, instrValid}, 32'd0);
    check("rw_req2", {31'b0, imemReq}, 32'd1);
    $display("late rvalid pc=%h instr=%h", pc, instrCode);
    model_pc = 32'h0;
    fetch(0, 32'h0000_0093);
    retire_op(0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
